// File: rtl/prog_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_clock_divider: per-channel programmable divided clock with tick strobe |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module prog_clock_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_1M,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] C_DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] pend;
  logic [CNT_W-1:0]  wr_div;

  // Divisors below 2 cannot form a period with both phases, so they are lifted to 2.
  assign wr_div = (cfg_div < C_DIV_MIN) ? C_DIV_MIN : cfg_div;

  // An out-of-range channel selects nothing, so it reads ready and is silently dropped.
  assign cfg_ready = ~|(ch_sel & pend);

  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] d);
    return d - (d >> 1);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] da_q, da_d;
    logic [CNT_W-1:0] ds_q, ds_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_en;
    logic             wrap;
    logic [CNT_W-1:0] da_eff;

    assign ch_sel[i]  = (cfg_ch == CH_W'(i));
    assign pend[i]    = pend_q;
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;

    always_comb begin
      da_d   = da_q;
      ds_d   = ds_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      da_eff = da_q;
      wr_en  = cfg_valid && ch_sel[i] && !pend_q;
      wrap   = (cnt_q >= (da_q - C_ONE));

      // A write only lands when nothing is pending, so it never collides with an apply.
      if (wr_en) begin
        ds_d   = wr_div;
        pend_d = 1'b1;
      end

      if (!en[i]) begin
        // Parking at Da-1 makes the first enabled edge a wrap, giving a clean rise.
        if (pend_q) begin
          da_d   = ds_q;
          pend_d = 1'b0;
          cnt_d  = ds_q - C_ONE;
        end else begin
          cnt_d = da_q - C_ONE;
        end
      end else begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            da_d   = ds_q;
            pend_d = 1'b0;
            da_eff = ds_q;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
        clk_d  = (cnt_d < high_len(da_eff));
        tick_d = (cnt_d == '0);
      end
    end

    always_ff @(posedge clock_1M or negedge reset) begin
      if (!reset) begin
        da_q   <= C_DIV_RST;
        ds_q   <= C_DIV_RST;
        cnt_q  <= C_DIV_RST - C_ONE;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        da_q   <= da_d;
        ds_q   <= ds_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_clock_divider: randomized and directed bench with period model     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_prog_clock_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEFDIV = 10;

  logic              clock_1M = 1'b0;
  logic              reset    = 1'b1;
  logic [NUM_CH-1:0] en       = '0;
  logic              cfg_valid = 1'b0;
  logic [1:0]        cfg_ch   = '0;
  logic [CNT_W-1:0]  cfg_div  = '0;
  logic              cfg_ready;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  prog_clock_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEFDIV)
  ) dut (
    .clock_1M(clock_1M),
    .reset(reset),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clock_1M = ~clock_1M;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel is either idle or at some phase of a period of length
  // m_da; high for the first ceil(m_da/2) phases, tick on phase 0.
  int m_da[NUM_CH];
  int m_ds[NUM_CH];
  int m_phase[NUM_CH];
  bit m_p[NUM_CH];
  bit m_run[NUM_CH];
  bit m_clk[NUM_CH];
  bit m_tick[NUM_CH];

  always @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_da[c] = DEFDIV; m_ds[c] = DEFDIV; m_phase[c] = 0;
        m_p[c] = 0; m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit acc;
        acc = cfg_valid && (int'(cfg_ch) == c) && !m_p[c];
        if (!en[c]) begin
          if (m_p[c]) begin m_da[c] = m_ds[c]; m_p[c] = 0; end
          m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        end else begin
          if (!m_run[c] || m_phase[c] == m_da[c] - 1) begin
            if (m_p[c]) begin m_da[c] = m_ds[c]; m_p[c] = 0; end
            m_phase[c] = 0;
            m_run[c] = 1;
          end else begin
            m_phase[c] = m_phase[c] + 1;
          end
          m_clk[c]  = (m_phase[c] < (m_da[c] + 1) / 2);
          m_tick[c] = (m_phase[c] == 0);
        end
        if (acc) begin
          m_ds[c] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
          m_p[c]  = 1;
        end
      end
    end
  end

  always @(negedge clock_1M) begin
    if (chk_on) begin
      logic [NUM_CH-1:0] ec;
      logic [NUM_CH-1:0] et;
      logic er;
      for (int c = 0; c < NUM_CH; c++) begin
        ec[c] = m_clk[c];
        et[c] = m_tick[c];
      end
      er = 1'b1;
      if (int'(cfg_ch) < NUM_CH) er = !m_p[cfg_ch];
      chk("model_clk_out", int'(clk_out), int'(ec));
      chk("model_tick", int'(tick), int'(et));
      chk("model_cfg_ready", int'(cfg_ready), int'(er));
    end
  end

  // Period/high-time measurement between consecutive ticks of each channel.
  int since[NUM_CH];
  int hi_acc[NUM_CH];
  int last_per[NUM_CH];
  int last_hi[NUM_CH];
  int tick_cnt[NUM_CH];
  bit seen[NUM_CH];

  always @(negedge clock_1M) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!reset) begin
        seen[c] = 0;
      end else if (tick[c]) begin
        if (seen[c]) begin
          last_per[c] = since[c];
          last_hi[c]  = hi_acc[c];
        end
        since[c]  = 1;
        hi_acc[c] = clk_out[c] ? 1 : 0;
        seen[c]   = 1;
        tick_cnt[c] = tick_cnt[c] + 1;
      end else begin
        since[c]  = since[c] + 1;
        hi_acc[c] = hi_acc[c] + (clk_out[c] ? 1 : 0);
      end
    end
  end

  task automatic wait_ticks(input int ch, input int n);
    int target;
    int cyc;
    target = tick_cnt[ch] + n;
    cyc = 0;
    while (tick_cnt[ch] < target && cyc < 400) begin
      @(negedge clock_1M); #1;
      cyc++;
    end
    if (tick_cnt[ch] < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout ch%0d: got %0d ticks expected %0d", ch, tick_cnt[ch], target);
    end
  endtask

  task automatic cfg_write(input int ch, input int d);
    @(posedge clock_1M); #2;
    cfg_valid = 1'b1;
    cfg_ch    = ch[1:0];
    cfg_div   = d[7:0];
    @(posedge clock_1M); #2;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int rst_hold;
    int idx;
    #1 reset = 1'b0;
    #1 chk_on = 1'b1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // Writes while held in reset must be ignored.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
    repeat (3) @(posedge clock_1M);
    #2 cfg_valid = 1'b0;
    chk("rst_cfg_ready_hold", int'(cfg_ready), 1);

    reset = 1'b1;
    en = 3'b111;
    @(posedge clock_1M);
    @(negedge clock_1M); #1;
    chk("first_tick", int'(tick), 7);
    chk("first_clk", int'(clk_out), 7);
    wait_ticks(0, 1);
    chk("def_per0", last_per[0], 10);
    chk("def_hi0", last_hi[0], 5);
    chk("def_per1", last_per[1], 10);

    cfg_write(0, 5);
    cfg_write(1, 100);
    wait_ticks(0, 2);
    chk("d5_per", last_per[0], 5);
    chk("d5_hi", last_hi[0], 3);
    wait_ticks(1, 2);
    chk("d100_per", last_per[1], 100);
    chk("d100_hi", last_hi[1], 50);

    cfg_write(0, 10);
    wait_ticks(0, 2);
    chk("d10_per", last_per[0], 10);
    repeat (2) @(posedge clock_1M);
    cfg_write(0, 4);
    #1 chk("pend_ready_low", int'(cfg_ready), 0);
    cfg_write(0, 7);
    wait_ticks(0, 1);
    chk("pend_full_per", last_per[0], 10);
    chk("pend_full_hi", last_hi[0], 5);
    wait_ticks(0, 1);
    chk("d4_per", last_per[0], 4);
    chk("d4_hi", last_hi[0], 2);
    wait_ticks(0, 1);
    chk("refused_per", last_per[0], 4);

    cfg_write(0, 0);
    wait_ticks(0, 3);
    chk("d0_per", last_per[0], 2);
    chk("d0_hi", last_hi[0], 1);
    cfg_write(0, 1);
    wait_ticks(0, 3);
    chk("d1_per", last_per[0], 2);
    chk("d1_hi", last_hi[0], 1);

    @(posedge clock_1M); #2;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd50;
    #1 chk("oor_ready", int'(cfg_ready), 1);
    @(posedge clock_1M); #2 cfg_valid = 1'b0;
    wait_ticks(0, 3);
    chk("oor_per0", last_per[0], 2);
    wait_ticks(1, 1);
    chk("oor_per1", last_per[1], 100);

    cfg_write(0, 8);
    wait_ticks(0, 2);
    chk("d8_per", last_per[0], 8);
    repeat (6) @(posedge clock_1M);
    cfg_write(0, 3);
    wait_ticks(0, 1);
    chk("wrapwr_per_a", last_per[0], 8);
    wait_ticks(0, 1);
    chk("wrapwr_per_b", last_per[0], 8);
    wait_ticks(0, 1);
    chk("d3_per", last_per[0], 3);
    chk("d3_hi", last_hi[0], 2);

    wait_ticks(0, 1);
    en[0] = 1'b0;
    @(negedge clock_1M); #1;
    chk("dis_clk", int'(clk_out[0]), 0);
    chk("dis_tick", int'(tick[0]), 0);
    cfg_write(0, 6);
    repeat (3) @(negedge clock_1M);
    #1 chk("dis_clk_hold", int'(clk_out[0]), 0);
    @(posedge clock_1M); #2 en[0] = 1'b1;
    @(posedge clock_1M);
    @(negedge clock_1M); #1;
    chk("reen_clk", int'(clk_out[0]), 1);
    chk("reen_tick", int'(tick[0]), 1);
    wait_ticks(0, 1);
    chk("d6_per", last_per[0], 6);
    chk("d6_hi", last_hi[0], 3);

    wait_ticks(1, 1);
    cfg_write(1, 20);
    #1 chk("rst_pend_ready", int'(cfg_ready), 0);
    reset = 1'b0;
    #1;
    chk("midrst_clk", int'(clk_out), 0);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_ready", int'(cfg_ready), 1);
    repeat (2) @(posedge clock_1M);
    #2 reset = 1'b1;
    wait_ticks(1, 2);
    chk("postrst_per1", last_per[1], 10);
    chk("postrst_hi1", last_hi[1], 5);
    chk("postrst_per0", last_per[0], 10);

    rst_hold = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clock_1M); #2;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        rst_hold = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 29) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        en[idx] = ~en[idx];
      end
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) cfg_div = 8'($urandom_range(0, 9));
      else cfg_div = 8'($urandom_range(0, 255));
    end
    cfg_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock_1M); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
